twiddle_rom_reader: RTL and testbench

- Read-side client of the single-port twiddle-factor ROM (128 entries, {cos,sin} packed) used by the FFT butterfly datapath.
- Generates strided ROM addresses for one FFT stage and tracks the fixed ROM read latency.
- Delivers twiddles as a valid/ready stream, with a small buffer that absorbs in-flight reads when the butterfly stalls.

---
 rtl/fft_tw_pkg.sv | 29 ++
 rtl/twr_fifo.sv | 53 +++++
 rtl/twiddle_rom_reader.sv | 153 +++++++++++++++
 tb/tb_twiddle_rom_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_tw_pkg.sv
// Shared definitions for the FFT twiddle path: default widths, reader FSM
// encoding, {cos,sin} field extractors and the output-buffer sizing rule.
package fft_tw_pkg;

    localparam int TW_ADDR_W = 7;
    localparam int TW_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } twr_state_t;

    // One slot per in-flight read plus one for the head and one so that
    // issue can continue while the head is being consumed.
    function automatic int fifo_depth(input int rom_lat);
        return rom_lat + 2;
    endfunction

    function automatic logic [TW_DATA_W/2-1:0] tw_re(input logic [TW_DATA_W-1:0] w);
        return w[TW_DATA_W-1:TW_DATA_W/2];
    endfunction

    function automatic logic [TW_DATA_W/2-1:0] tw_im(input logic [TW_DATA_W-1:0] w);
        return w[TW_DATA_W/2-1:0];
    endfunction

endpackage

// File: rtl/twr_fifo.sv
// Small synchronous FIFO with occupancy output; push and pop may coincide at
// any fill level (a pop frees the slot the push needs when full).
module twr_fifo #(
    parameter  int WIDTH    = 33,
    parameter  int DEPTH    = 4,
    localparam int CNT_BITS = $clog2(DEPTH + 1),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [WIDTH-1:0]    i_data,
    input  logic                i_pop,
    output logic [WIDTH-1:0]    o_data,
    output logic [CNT_BITS-1:0] o_count
);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                w_do_pop;
    logic                w_do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_BITS'(DEPTH)) || w_do_pop);

    // NOTE: the storage is reset too, so the head word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/twiddle_rom_reader.sv
// Strided twiddle-ROM reader with latency tracking and a credit-guarded output
// buffer. Define TWR_CONJ_EN to add the conj input (saturating imag negation).
module twiddle_rom_reader
    import fft_tw_pkg::*;
#(
    parameter int ADDR_W  = TW_ADDR_W,
    parameter int DATA_W  = TW_DATA_W,
    parameter int ROM_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  len,
`ifdef TWR_CONJ_EN
    input  logic              conj,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_clk_en,
    output logic              rom_rd_oce,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [DATA_W-1:0] tw_data,
    output logic              tw_last
);

    localparam int FIFO_DEPTH = fifo_depth(ROM_LAT);
    localparam int CB         = $clog2(FIFO_DEPTH + 1);
    localparam int HALF       = DATA_W / 2;

    twr_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_stride;
    logic [CNT_W-1:0]  r_len, r_issued, r_pushed;
    logic [ROM_LAT-1:0] r_vsr;
    logic [CB-1:0]     r_inflight, w_fifo_count;
    logic              w_issue, w_push, w_pop, w_credit_ok, w_load;
    logic              w_push_last, w_head_last;
    logic [DATA_W-1:0] w_push_data, w_head_data;

    assign w_load      = (r_state == ST_IDLE) && start && (len != '0);
    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < (CB + 1)'(FIFO_DEPTH);
    assign w_push      = r_vsr[ROM_LAT-1];
    assign w_pop       = tw_valid && tw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = (len == '0) ? ST_FIN : ST_RUN;
            ST_RUN: begin
                busy    = 1'b1;
                w_issue = (r_issued < r_len) && w_credit_ok;
                if (r_issued == r_len) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Nothing left in the ROM pipe and the buffer empties this cycle.
                if ((r_inflight == '0) &&
                    ((w_fifo_count == '0) || ((w_fifo_count == CB'(1)) && w_pop)))
                    w_next = ST_FIN;
            end
            ST_FIN: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_stride   <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_pushed   <= '0;
            r_vsr      <= '0;
            r_inflight <= '0;
        end else begin
            r_vsr      <= (r_vsr << 1) | ROM_LAT'(w_issue);
            r_inflight <= r_inflight + CB'(w_issue) - CB'(w_push);
            if (w_load) begin
                r_addr   <= base;
                r_stride <= stride;
                r_len    <= len;
                r_issued <= '0;
                r_pushed <= '0;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + r_stride;
                    r_issued <= r_issued + 1'b1;
                end
                if (w_push) r_pushed <= r_pushed + 1'b1;
            end
        end
    end

    assign w_push_last = (r_pushed == r_len - 1'b1);

`ifdef TWR_CONJ_EN
    logic            r_conj;
    logic [HALF-1:0] w_im_raw, w_im_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_conj <= 1'b0;
        else if (w_load) r_conj <= conj;
    end

    // The most negative value has no positive twin; clamp it to the maximum.
    assign w_im_raw    = rom_rd_data[HALF-1:0];
    assign w_im_neg    = (w_im_raw == {1'b1, {(HALF-1){1'b0}}}) ? {1'b0, {(HALF-1){1'b1}}}
                                                                : -w_im_raw;
    assign w_push_data = r_conj ? {rom_rd_data[DATA_W-1:HALF], w_im_neg} : rom_rd_data;
`else
    assign w_push_data = rom_rd_data;
`endif

    twr_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_push_last, w_push_data}),
        .i_pop   (w_pop),
        .o_data  ({w_head_last, w_head_data}),
        .o_count (w_fifo_count)
    );

    assign rom_addr   = r_addr;
    assign rom_clk_en = w_issue || (r_inflight != '0);
    assign rom_rd_oce = rom_clk_en;
    assign tw_valid   = (w_fifo_count != '0);
    assign tw_data    = w_head_data;
    assign tw_last    = tw_valid && w_head_last;

endmodule

// File: tb/tb_twiddle_rom_reader.sv
// Self-checking bench for twiddle_rom_reader: ROM model with ROM_LAT stages,
// scoreboard of expected twiddles, directed timing/stall/reset/len=0 cases.
module tb_twiddle_rom_reader;
    import fft_tw_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  base, stride;
    logic [7:0]  len;
    logic        busy, done, rom_clk_en, rom_rd_oce;
    logic [6:0]  rom_addr;
    logic [31:0] rom_rd_data;
    logic        tw_valid, tw_ready, tw_last;
    logic [31:0] tw_data;
`ifdef TWR_CONJ_EN
    logic        conj;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rom [128];
    logic [31:0] rom_pipe [LAT];
    int          n_checks = 0;
    int          n_errors = 0;

    twiddle_rom_reader #(.ROM_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base        (base),
        .stride      (stride),
        .len         (len),
`ifdef TWR_CONJ_EN
        .conj        (conj),
`endif
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_clk_en  (rom_clk_en),
        .rom_rd_oce  (rom_rd_oce),
        .rom_rd_data (rom_rd_data),
        .tw_valid    (tw_valid),
        .tw_ready    (tw_ready),
        .tw_data     (tw_data),
        .tw_last     (tw_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_clk_en) begin
            rom_pipe[0] <= rom[rom_addr];
            for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
        end
    end
    assign rom_rd_data = rom_pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_neg(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7fff;
        return 16'h0000 - x;
    endfunction

    function automatic logic [31:0] model_word(input logic [6:0] a, input logic cj);
        logic [31:0] w;
        w = rom[a];
        return cj ? {tw_re(w), sat_neg(tw_im(w))} : w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a start pulse and queues what the request should deliver.
    task automatic start_req(input logic [6:0] b, input logic [6:0] s,
                             input logic [7:0] l, input logic cj);
        logic [6:0] a;
        base = b; stride = s; len = l; start = 1'b1;
`ifdef TWR_CONJ_EN
        conj = cj;
`endif
        for (int i = 0; i < int'(l); i++) begin
            a = b + 7'(i * int'(s));
            sb.push_back('{model_word(a, cj), (i == int'(l) - 1)});
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd_ready);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (rnd_ready) tw_ready = 1'($urandom_range(0, 1));
            step();
            if (done) seen = 1'b1;
        end
        tw_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_all_delivered"}, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare on handshake, hold check while stalled.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(tw_valid), 64'd1);
                check("hold_data", 64'(tw_data), 64'(prev_data));
                check("hold_last", 64'(tw_last), 64'(prev_last));
            end
            if (tw_valid && tw_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_twiddle", 64'(tw_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("tw_data", 64'(tw_data), 64'(e.data));
                    check("tw_last", 64'(tw_last), 64'(e.last));
                end
            end
            prev_stall = tw_valid && !tw_ready;
            prev_data  = tw_data;
            prev_last  = tw_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int maxc;
        for (int i = 0; i < 128; i++)
            rom[i] = {16'(i * 257 + 3), 16'(16'ha5a5 ^ 16'(i * 977))};
        rst_n = 1'b0; start = 1'b0; base = '0; stride = '0; len = '0; tw_ready = 1'b1;
`ifdef TWR_CONJ_EN
        conj = 1'b0;
`endif
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_rom_clk_en", 64'(rom_clk_en), 64'd0);
        check("rst_tw_valid", 64'(tw_valid), 64'd0);
        check("rst_tw_last", 64'(tw_last), 64'd0);
        check("rst_tw_data", 64'(tw_data), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic timeline: len=4, base=0, stride=1, always ready.
        start_req(7'd0, 7'd1, 8'd4, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k <= 4) begin
                check($sformatf("t1_rom_addr_c%0d", k), 64'(rom_addr), 64'(k - 1));
                check($sformatf("t1_rom_clk_en_c%0d", k), 64'(rom_clk_en), 64'd1);
            end
            check($sformatf("t1_oce_c%0d", k), 64'(rom_rd_oce), 64'(rom_clk_en));
            check($sformatf("t1_tw_valid_c%0d", k), 64'(tw_valid), 64'(k >= 4 && k <= 7));
            check($sformatf("t1_tw_last_c%0d", k), 64'(tw_last), 64'(k == 7));
            check($sformatf("t1_done_c%0d", k), 64'(done), 64'(k == 8));
            check($sformatf("t1_busy_c%0d", k), 64'(busy), 64'(k <= 8));
            step();
        end
        check("t1_all_delivered", 64'(sb.size()), 64'd0);

        // Address wrap past the top of the table.
        start_req(7'd120, 7'd3, 8'd8, 1'b0);
        wait_done("wrap", 60, 1'b0);
        step();

        // Long stall: buffer fills, ROM gated off, nothing lost.
        start_req(7'd10, 7'd1, 8'd16, 1'b0);
        maxc = 0;
        for (int k = 1; k <= 14; k++) begin
            tw_ready = !(k >= 3 && k <= 12);
            if (k >= 8 && k <= 12) begin
                check($sformatf("stall_rom_clk_en_c%0d", k), 64'(rom_clk_en), 64'd0);
                check($sformatf("stall_tw_valid_c%0d", k), 64'(tw_valid), 64'd1);
            end
            if (int'(dut.w_fifo_count) > maxc) maxc = int'(dut.w_fifo_count);
            step();
        end
        tw_ready = 1'b1;
        check("stall_max_fifo_count", 64'(maxc), 64'd4);
        wait_done("stall", 80, 1'b0);
        step();

        // len=0: done without touching the ROM.
        start_req(7'd3, 7'd1, 8'd0, 1'b0);
        check("len0_done_c1", 64'(done), 64'd1);
        check("len0_busy_c1", 64'(busy), 64'd1);
        check("len0_rom_clk_en_c1", 64'(rom_clk_en), 64'd0);
        check("len0_tw_valid_c1", 64'(tw_valid), 64'd0);
        step();
        check("len0_done_c2", 64'(done), 64'd0);
        check("len0_busy_c2", 64'(busy), 64'd0);
        check("len0_rom_clk_en_c2", 64'(rom_clk_en), 64'd0);
        check("len0_tw_valid_c2", 64'(tw_valid), 64'd0);
        step();

        // Random backpressure plus a start pulse while busy that must be ignored.
        start_req(7'($urandom), 7'($urandom), 8'd20, 1'b0);
        step();
        base = 7'd99; stride = 7'd5; len = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("random", 400, 1'b1);
        step();

        // Reset while element 5 of a len=10 request is on the output.
        start_req(7'd5, 7'd1, 8'd10, 1'b0);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
        check("mid_rst_rom_clk_en", 64'(rom_clk_en), 64'd0);
        check("mid_rst_tw_valid", 64'(tw_valid), 64'd0);
        check("mid_rst_tw_last", 64'(tw_last), 64'd0);
        check("mid_rst_tw_data", 64'(tw_data), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_no_done", 64'(done), 64'd0);
        end
        start_req(7'd7, 7'd5, 8'd2, 1'b0);
        wait_done("post_rst", 50, 1'b0);
        step();

`ifdef TWR_CONJ_EN
        rom[100] = {16'h4000, 16'h8000};
        rom[101] = {16'h1111, 16'h1234};
        start_req(7'd100, 7'd1, 8'd2, 1'b1);
        wait_done("conj_on", 50, 1'b0);
        step();
        start_req(7'd100, 7'd1, 8'd2, 1'b0);
        wait_done("conj_off", 50, 1'b0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
